// File: rtl/cpu_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package cpu_pkg;

    localparam int unsigned MULDIV_ITERS = 32;
    localparam int unsigned MULDIV_CNT_W = 6;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MULT,
        ST_DIV,
        ST_FIXUP,
        ST_DONE
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// Booth multiply / restoring divide datapath that owns the HI/LO registers.
module muldiv_datapath
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             step_mult,
    input  logic             step_div,
    input  logic             fixup,
    input  logic             commit,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned PW = 2 * WIDTH + 1;

    logic [PW-1:0]    prod_q, prod_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             op_q, op_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   booth_acc, booth_m, booth_sum;
    logic [WIDTH:0]   trial_r;
    logic             trial_ge;

    always_comb begin
        prod_d = prod_q;
        m_d    = m_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        op_d   = op_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;

        a_mag = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
        b_mag = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;

        // Accumulator is sign-extended by one bit so the -2^(W-1) multiplicand cannot overflow.
        booth_acc = {prod_q[PW-1], prod_q[PW-1 -: WIDTH]};
        booth_m   = {m_q[WIDTH-1], m_q};
        case (prod_q[1:0])
            2'b01:   booth_sum = booth_acc + booth_m;
            2'b10:   booth_sum = booth_acc - booth_m;
            default: booth_sum = booth_acc;
        endcase

        trial_r  = {rem_q, quo_q[WIDTH-1]};
        trial_ge = (trial_r >= {1'b0, m_q});

        if (load) begin
            op_d = op;
            if (op == OP_MULT) begin
                prod_d = {{WIDTH{1'b0}}, b, 1'b0};
                m_d    = a;
            end else begin
                m_d    = b_mag;
                quo_d  = a_mag;
                rem_d  = '0;
                qneg_d = a[WIDTH-1] ^ b[WIDTH-1];
                rneg_d = a[WIDTH-1];
            end
        end

        if (step_mult) begin
            prod_d = {booth_sum, prod_q[WIDTH:1]};
        end

        if (step_div) begin
            rem_d = trial_ge ? WIDTH'(trial_r - {1'b0, m_q}) : trial_r[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], trial_ge};
        end

        if (fixup) begin
            quo_d = qneg_q ? (~quo_q + WIDTH'(1)) : quo_q;
            rem_d = rneg_q ? (~rem_q + WIDTH'(1)) : rem_q;
        end

        if (commit) begin
            hi_d = (op_q == OP_DIV) ? rem_q : prod_q[PW-1 -: WIDTH];
            lo_d = (op_q == OP_DIV) ? quo_q : prod_q[WIDTH:1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod_q <= '0;
            m_q    <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            op_q   <= 1'b0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            prod_q <= prod_d;
            m_q    <= m_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            op_q   <= op_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/mult_div_ctrl.sv
// Multiply/divide sequencer: accepts one MULT/DIV request and drives the datapath strobes.
module mult_div_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [MULDIV_CNT_W-1:0] CNT_LAST = MULDIV_CNT_W'(MULDIV_ITERS - 1);

    muldiv_state_t           state_q, state_d;
    logic [MULDIV_CNT_W-1:0] cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    div_zero_q, div_zero_d;
    logic                    dz_pend_q, dz_pend_d;

    logic load_c, step_mult_c, step_div_c, fixup_c, commit_c;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = (state_q != ST_IDLE);
        done_d      = 1'b0;
        div_zero_d  = 1'b0;
        dz_pend_d   = dz_pend_q;
        load_c      = 1'b0;
        step_mult_c = 1'b0;
        step_div_c  = 1'b0;
        fixup_c     = 1'b0;
        commit_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d     = '0;
                    dz_pend_d = 1'b0;
                    if (op == OP_MULT) begin
                        load_c  = 1'b1;
                        state_d = ST_MULT;
                    end else if (b == '0) begin
                        dz_pend_d = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        load_c  = 1'b1;
                        state_d = ST_DIV;
                    end
                end
            end
            ST_MULT: begin
                step_mult_c = 1'b1;
                if (cnt_q == CNT_LAST) state_d = ST_DONE;
                else                   cnt_d   = cnt_q + MULDIV_CNT_W'(1);
            end
            ST_DIV: begin
                step_div_c = 1'b1;
                if (cnt_q == CNT_LAST) state_d = ST_FIXUP;
                else                   cnt_d   = cnt_q + MULDIV_CNT_W'(1);
            end
            ST_FIXUP: begin
                fixup_c = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                // A divide-by-zero completes without touching HI/LO.
                done_d     = 1'b1;
                div_zero_d = dz_pend_q;
                commit_c   = ~dz_pend_q;
                dz_pend_d  = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            dz_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            dz_pend_q  <= dz_pend_d;
        end
    end

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk       (clk),
        .reset     (reset),
        .load      (load_c),
        .op        (op),
        .a         (a),
        .b         (b),
        .step_mult (step_mult_c),
        .step_div  (step_div_c),
        .fixup     (fixup_c),
        .commit    (commit_c),
        .hi        (hi),
        .lo        (lo)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed bench for mult_div_ctrl: latency, HI/LO results, div-by-zero, back-to-back and abort.
module tb_mult_div_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mult_div_ctrl #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one op, follows it cycle by cycle and checks outputs; chain leaves the
    // done cycle as the last one so the caller can issue the next op immediately.
    task automatic run_op(input string nm, input logic o, input logic [31:0] ia, input logic [31:0] ib,
                          input int lat, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz, input bit chain);
        int bad_busy = 0;
        int bad_done = 0;
        int bad_dz   = 0;
        int bad_hold = 0;
        start = 1'b1; op = o; a = ia; b = ib;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; a = $urandom; b = $urandom;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy_c0: busy=%b required 0", nm, busy);
        end
        for (int n = 1; n <= lat; n++) begin
            @(posedge clk); #1;
            if (busy !== 1'b1) bad_busy++;
            if (done !== 1'(n == lat)) bad_done++;
            if (div_zero !== 1'(edz && (n == lat))) bad_dz++;
            if (n < lat && (hi !== m_hi || lo !== m_lo)) bad_hold++;
        end
        checks++;
        if (hi !== ehi) begin
            failures++;
            $display("FAIL %s_hi: hi=%h required %h", nm, hi, ehi);
        end
        checks++;
        if (lo !== elo) begin
            failures++;
            $display("FAIL %s_lo: lo=%h required %h", nm, lo, elo);
        end
        m_hi = ehi;
        m_lo = elo;
        if (!chain) begin
            @(posedge clk); #1;
            if (busy !== 1'b0) bad_busy++;
            if (done !== 1'b0) bad_done++;
            if (div_zero !== 1'b0) bad_dz++;
            if (hi !== m_hi || lo !== m_lo) bad_hold++;
        end
        checks++;
        if (bad_busy != 0) begin
            failures++;
            $display("FAIL %s_busy: %0d cycles wrong, required 0", nm, bad_busy);
        end
        checks++;
        if (bad_done != 0) begin
            failures++;
            $display("FAIL %s_done: %0d cycles wrong (done pulse expected in cycle %0d only)", nm, bad_done, lat);
        end
        checks++;
        if (bad_dz != 0) begin
            failures++;
            $display("FAIL %s_div_zero: %0d cycles wrong, required 0", nm, bad_dz);
        end
        checks++;
        if (bad_hold != 0) begin
            failures++;
            $display("FAIL %s_hold: hi/lo changed outside done in %0d cycles, required 0", nm, bad_hold);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: busy=%b done=%b div_zero=%b required 0 0 0", busy, done, div_zero);
        end
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            failures++;
            $display("FAIL reset_hilo: hi=%h lo=%h required 0 0", hi, lo);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_mult;
        run_op("mult_7xm3",    1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);
        run_op("mult_maxsq",   1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 33, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op("mult_m5xm6",   1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 33, 32'h0000_0000, 32'h0000_001E, 1'b0, 1'b0);
        run_op("mult_minsq",   1'b0, 32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0);
    endtask

    task automatic test_div;
        run_op("div_m7d2",     1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run_op("div_ovf",      1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);
        run_op("div_100d7",    1'b1, 32'd100,       32'd7,         34, 32'h0000_0002, 32'h0000_000E, 1'b0, 1'b0);
        run_op("div_7dm2",     1'b1, 32'd7,         32'hFFFF_FFFE, 34, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b0);
    endtask

    task automatic test_div_zero;
        run_op("dz_preload",   1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);
        run_op("dz_5d0",       1'b1, 32'd5,         32'd0,         1,  32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_op("b2b_mult",     1'b0, 32'd3,   32'd5, 33, 32'h0000_0000, 32'h0000_000F, 1'b0, 1'b1);
        run_op("b2b_div",      1'b1, 32'd100, 32'd7, 34, 32'h0000_0002, 32'h0000_000E, 1'b0, 1'b1);
        run_op("b2b_dz",       1'b1, 32'd9,   32'd0, 1,  32'h0000_0002, 32'h0000_000E, 1'b1, 1'b0);
    endtask

    task automatic test_abort;
        int bad_busy = 0;
        int done_seen = 0;
        start = 1'b1; op = 1'b0; a = 32'h1234_5678; b = 32'h0000_0003;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (busy !== 1'b1) bad_busy++;
            if (done !== 1'b0) done_seen++;
            if (n == 5) begin
                start = 1'b1; op = 1'b1; a = 32'd5; b = 32'd0;
            end
            if (n == 8) start = 1'b0;
        end
        checks++;
        if (bad_busy != 0 || done_seen != 0) begin
            failures++;
            $display("FAIL abort_ignore_start: busy wrong %0d cycles, done seen %0d, required 0 0", bad_busy, done_seen);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_flags: busy=%b done=%b required 0 0", busy, done);
        end
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            failures++;
            $display("FAIL abort_hilo: hi=%h lo=%h required 0 0", hi, lo);
        end
        m_hi = '0;
        m_lo = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        bad_busy = 0;
        done_seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (busy !== 1'b0) bad_busy++;
            if (done !== 1'b0 || div_zero !== 1'b0) done_seen++;
        end
        checks++;
        if (bad_busy != 0 || done_seen != 0) begin
            failures++;
            $display("FAIL abort_quiet: busy %0d cycles, done %0d cycles after reset, required 0 0", bad_busy, done_seen);
        end
        run_op("abort_3x4",    1'b0, 32'd3, 32'd4, 33, 32'h0000_0000, 32'h0000_000C, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
